// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the single-channel word-copy engine.
package bus_dma_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
endpackage

// File: rtl/bus_dma_if.sv
// Command handshake and data-bus signals of bus_dma. master = engine side, slave = host/memory side.
// BUS_DMA_FILL_EN adds cmd_fill (constant-fill command).
interface bus_dma_if #(parameter int LEN_W = 16);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [bus_dma_pkg::ADDR_W-1:0]    cmd_src;
  logic [bus_dma_pkg::ADDR_W-1:0]    cmd_dst;
  logic [LEN_W-1:0]                  cmd_len;
  logic                              cmd_abort;
`ifdef BUS_DMA_FILL_EN
  logic                              cmd_fill;
`endif
  logic                              busy;
  logic                              done;
  logic                              aborted;
  logic                              bus_r_en;
  logic [bus_dma_pkg::ADDR_W-1:0]    bus_r_addr;
  logic [31:0]                       bus_r_data;
  logic                              bus_w_en;
  logic [bus_dma_pkg::ADDR_W-1:0]    bus_w_addr;
  logic [31:0]                       bus_w_data;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_abort,
`ifdef BUS_DMA_FILL_EN
    input  cmd_fill,
`endif
    input  bus_r_data,
    output cmd_ready, busy, done, aborted,
    output bus_r_en, bus_r_addr, bus_w_en, bus_w_addr, bus_w_data
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_abort,
`ifdef BUS_DMA_FILL_EN
    output cmd_fill,
`endif
    output bus_r_data,
    input  cmd_ready, busy, done, aborted,
    input  bus_r_en, bus_r_addr, bus_w_en, bus_w_addr, bus_w_data
  );
endinterface

// File: rtl/bus_dma.sv
// Single-channel word-copy bus master: reads src, writes dst one word per cycle.
// Optional BUS_DMA_FILL_EN: constant-fill commands (write cmd_src as data, no reads).
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  bus_dma_if.master bus
);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_BYTES - 1));

  state_t            state;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       buf_data;
  logic              buf_vld;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              done_q, aborted_q, fill_q;
  logic              cmd_fill_in;
  logic [ADDR_W-1:0] src_al, dst_al;

`ifdef BUS_DMA_FILL_EN
  assign cmd_fill_in = bus.cmd_fill;
`else
  assign cmd_fill_in = 1'b0;
`endif

  assign src_al = bus.cmd_src & ALIGN_MASK;
  assign dst_al = bus.cmd_dst & ALIGN_MASK;

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.bus_r_en   = r_en;
  assign bus.bus_r_addr = r_addr;
  // The write port is the one-word buffer itself; data/addr are zeroed whenever it is invalid.
  assign bus.bus_w_en   = buf_vld;
  assign bus.bus_w_addr = w_addr;
  assign bus.bus_w_data = buf_data;

  // Bus outputs are registered as next-cycle values, so each branch below sets
  // what the bus shows in the following cycle; defaults drop everything to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      wr_addr   <= '0;
      remaining <= '0;
      buf_data  <= '0;
      buf_vld   <= 1'b0;
      r_en      <= 1'b0;
      r_addr    <= '0;
      w_addr    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      fill_q    <= 1'b0;
    end else begin
      r_en      <= 1'b0;
      r_addr    <= '0;
      buf_vld   <= 1'b0;
      buf_data  <= '0;
      w_addr    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            remaining <= bus.cmd_len;
            fill_q    <= cmd_fill_in;
            if (bus.cmd_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (cmd_fill_in) begin
              state    <= RUN;
              buf_vld  <= 1'b1;
              buf_data <= bus.cmd_src;
              w_addr   <= dst_al;
              wr_addr  <= dst_al + STEP;
            end else begin
              state   <= RUN;
              r_en    <= 1'b1;
              r_addr  <= src_al;
              rd_addr <= src_al + STEP;
              wr_addr <= dst_al;
            end
          end
        end
        RUN: begin
          remaining <= remaining - LEN_W'(1);
          if (bus.cmd_abort) begin
            state     <= DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (fill_q) begin
            if (remaining == LEN_W'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              buf_vld  <= 1'b1;
              buf_data <= buf_data;
              w_addr   <= wr_addr;
              wr_addr  <= wr_addr + STEP;
            end
          end else begin
            buf_vld  <= 1'b1;
            buf_data <= bus.bus_r_data;
            w_addr   <= wr_addr;
            wr_addr  <= wr_addr + STEP;
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end else begin
              r_en    <= 1'b1;
              r_addr  <= rd_addr;
              rd_addr <= rd_addr + STEP;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          done_q    <= 1'b1;
          aborted_q <= bus.cmd_abort;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
